// File: rtl/dac_frame_sched.sv
// Round-robin scheduler and serializer for an 8-bit serial DAC.
// Each frame is {control byte, sample}, shifted MSB first on sclk falls with a fixed sync-high gap.
module dac_frame_sched #(
    parameter logic [7:0]  CTRL0    = 8'b0001_0000,
    parameter logic [7:0]  CTRL1    = 8'b1001_0000,
    parameter int unsigned GAP_SCLK = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       busy,
    output logic       grant_id,
    output logic       frame_done,
    output logic       sclk,
    output logic       sync,
    output logic       din
);

    localparam int unsigned GW = (GAP_SCLK > 1) ? $clog2(GAP_SCLK) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t        state_q, state_d;
    logic          sclk_q, sclk_d;
    logic          sync_q, sync_d;
    logic          din_q, din_d;
    logic          done_q, done_d;
    logic          grant_q, grant_d;
    logic          last_q, last_d;
    logic [15:0]   frame_q, frame_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [GW-1:0] gapcnt_q, gapcnt_d;

    logic          fall;
    logic          grant_now;
    logic          pick1;
    logic [15:0]   sel_frame;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sclk_q   <= 1'b0;
            sync_q   <= 1'b1;
            din_q    <= 1'b0;
            done_q   <= 1'b0;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
            frame_q  <= '0;
            bitcnt_q <= '0;
            gapcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            sclk_q   <= sclk_d;
            sync_q   <= sync_d;
            din_q    <= din_d;
            done_q   <= done_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            frame_q  <= frame_d;
            bitcnt_q <= bitcnt_d;
            gapcnt_q <= gapcnt_d;
        end
    end

    always_comb begin
        fall      = sclk_q;
        // Contention goes to the channel not granted last; a lone valid always wins.
        pick1     = (req0_valid && req1_valid) ? ~last_q : req1_valid;
        grant_now = (state_q == ST_IDLE) && fall && (req0_valid || req1_valid);
        sel_frame = pick1 ? {CTRL1, req1_data} : {CTRL0, req0_data};

        state_d  = state_q;
        sclk_d   = ~sclk_q;
        sync_d   = sync_q;
        din_d    = din_q;
        done_d   = 1'b0;
        grant_d  = grant_q;
        last_d   = last_q;
        frame_d  = frame_q;
        bitcnt_d = bitcnt_q;
        gapcnt_d = gapcnt_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_now) begin
                    frame_d  = sel_frame;
                    grant_d  = pick1;
                    last_d   = pick1;
                    sync_d   = 1'b0;
                    din_d    = sel_frame[15];
                    bitcnt_d = '0;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (fall) begin
                    if (bitcnt_q != 4'd15) begin
                        // frame_q shifts left so bit [14] is always the next bit to send.
                        bitcnt_d = bitcnt_q + 4'd1;
                        din_d    = frame_q[14];
                        frame_d  = {frame_q[14:0], 1'b0};
                    end else begin
                        sync_d   = 1'b1;
                        din_d    = 1'b0;
                        done_d   = 1'b1;
                        gapcnt_d = '0;
                        state_d  = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (fall) begin
                    if (gapcnt_q == GW'(GAP_SCLK - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        gapcnt_d = gapcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign req0_ready = grant_now && !pick1;
    assign req1_ready = grant_now && pick1;
    assign busy       = (state_q != ST_IDLE);
    assign grant_id   = grant_q;
    assign frame_done = done_q;
    assign sclk       = sclk_q;
    assign sync       = sync_q;
    assign din        = din_q;

endmodule
